rr_mux_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one 4-to-1 mux datapath, for example a shared bus or operand port in the RISC-V core. It issues a registered one-hot grant and the matching 2-bit encoded select, which drives the mux `s1`/`s0` inputs directly. An owner holds the grant while its request stays high. A hold-limit counter forces rotation when other requesters are waiting, so no requester starves.

---
 rtl/rr_mux_arbiter4_if.sv | 23 ++
 rtl/rr_mux_arbiter4.sv | 132 +++++++++++++
 tb/tb_rr_mux_arbiter4.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter4_if.sv
// Request/grant bundle between four requesters and the shared 4-to-1 mux arbiter.
interface rr_mux_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  // Requester side: raises requests, observes grant and mux select.
  modport master (
    output req,
    input  gnt,
    input  sel,
    input  valid
  );

  // Arbiter side: samples requests, drives registered grant and select.
  modport slave (
    input  req,
    output gnt,
    output sel,
    output valid
  );
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Four-way round-robin arbiter for a shared 4-to-1 mux. Registered one-hot grant,
// encoded select for the mux s1/s0 inputs, and a hold limit that forces rotation
// under contention so no requester starves.
module rr_mux_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter4_if.slave     bus
);

  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q;
  logic [N-1:0]       gnt_q;
  logic [IDX_W-1:0]   sel_q;
  logic               valid_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [N-1:0]       req;
  logic [N-1:0]       owner_mask;
  logic [N-1:0]       others;
  logic               own_req;
  logic               at_limit;
  logic               rotate;
  logic [IDX_W:0]     idle_pick;
  logic [IDX_W:0]     busy_pick;
  logic [IDX_W:0]     pick;

  // First set bit of r searching upward from base with wrap; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = base + IDX_W'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // One-hot decode of an owner index.
  function automatic logic [N-1:0] dec(input logic [IDX_W-1:0] idx);
    return N'(1) << idx;
  endfunction

  assign req = bus.req;

  // Candidate winners: from the pointer when idle, from owner+1 (owner excluded) when busy.
  always_comb begin
    owner_mask = dec(sel_q);
    others     = req & ~owner_mask;
    own_req    = |(req & owner_mask);
    at_limit   = (cnt_q == CNT_MAX);
    rotate     = !own_req || (at_limit && (|others));
    idle_pick  = rr_pick(req, ptr_q);
    busy_pick  = rr_pick(others, sel_q + IDX_W'(1));
    pick       = (state_q == IDLE) ? idle_pick : busy_pick;
  end

  // Arbitration FSM with registered grant, select, valid, pointer and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick[IDX_W]) begin
            state_q <= BUSY;
            gnt_q   <= dec(pick[IDX_W-1:0]);
            sel_q   <= pick[IDX_W-1:0];
            valid_q <= 1'b1;
            ptr_q   <= pick[IDX_W-1:0] + IDX_W'(1);
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (rotate) begin
            if (pick[IDX_W]) begin
              // Zero-bubble handover or forced rotation to the next waiting requester.
              gnt_q   <= dec(pick[IDX_W-1:0]);
              sel_q   <= pick[IDX_W-1:0];
              valid_q <= 1'b1;
              ptr_q   <= pick[IDX_W-1:0] + IDX_W'(1);
              cnt_q   <= '0;
            end else begin
              // Owner released with nobody waiting; sel keeps the last owner.
              state_q <= IDLE;
              gnt_q   <= '0;
              valid_q <= 1'b0;
            end
          end else if (!at_limit) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

`ifndef SYNTHESIS
  // Grant never has two bits set.
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  // Valid mirrors a non-zero grant.
  a_valid: assert property (@(posedge clk) disable iff (rst) valid_q == (gnt_q != '0));
  // While granted, select points at the granted requester.
  a_sel: assert property (@(posedge clk) disable iff (rst) valid_q |-> gnt_q == dec(sel_q));
  // Hold counter never exceeds its saturation value.
  a_cnt: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_MAX);
`endif

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Bench for rr_mux_arbiter4: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-free behavioural model.
module tb_rr_mux_arbiter4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_mux_arbiter4_if if8 ();
  rr_mux_arbiter4_if if1 ();

  rr_mux_arbiter4 #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  rr_mux_arbiter4 #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per DUT (0: HOLD_MAX=8, 1: HOLD_MAX=1). Owner -1 means nobody granted.
  int m_own [2];
  int m_held[2];
  int m_ptr [2];
  int m_sel [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int base, input int excl);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (base + k) % 4;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  // Behavioural model: owner keeps the grant while requesting, unless it has held
  // for HOLD_MAX cycles and someone else is waiting.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_own[d] = -1; m_held[d] = 0; m_ptr[d] = 0; m_sel[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] r;
        int h;
        int w;
        r = (d == 0) ? if8.req : if1.req;
        h = (d == 0) ? 8 : 1;
        w = -1;
        if (m_own[d] < 0) begin
          w = first_from(r, m_ptr[d], -1);
        end else if (!r[m_own[d]]) begin
          w = first_from(r, m_own[d] + 1, m_own[d]);
          if (w < 0) m_own[d] = -1;
        end else if (m_held[d] >= h && (r & ~(4'b0001 << m_own[d])) != 4'b0000) begin
          w = first_from(r, m_own[d] + 1, m_own[d]);
        end else begin
          m_held[d]++;
        end
        if (w >= 0) begin
          m_own[d]  = w;
          m_held[d] = 1;
          m_sel[d]  = w;
          m_ptr[d]  = (w + 1) % 4;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic [6:0] act;
        logic [6:0] exp;
        logic [3:0] eg;
        eg  = (m_own[d] < 0) ? 4'b0000 : 4'(4'b0001 << m_own[d]);
        exp = {eg, 2'(m_sel[d]), (m_own[d] >= 0)};
        act = (d == 0) ? {if8.gnt, if8.sel, if8.valid} : {if1.gnt, if1.sel, if1.valid};
        check((d == 0) ? "model_h8" : "model_h1", 32'(act), 32'(exp));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setreq(input logic [3:0] v);
    if8.req = v;
    if1.req = v;
  endtask

  task automatic exp8(input string name, input logic [3:0] g, input logic [1:0] s, input logic v);
    check(name, 32'({if8.gnt, if8.sel, if8.valid}), 32'({g, s, v}));
  endtask

  task automatic exp1(input string name, input logic [3:0] g, input logic [1:0] s, input logic v);
    check(name, 32'({if1.gnt, if1.sel, if1.valid}), 32'({g, s, v}));
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear before any edge.
  task automatic mid_reset(input string name);
    #2 rst = 1'b1;
    #1;
    exp8(name, 4'b0000, 2'b00, 1'b0);
    exp1(name, 4'b0000, 2'b00, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    setreq(4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp8("reset_state", 4'b0000, 2'b00, 1'b0);

    // Full contention after reset: 0,1,2,3,0 for 8 cycles each, no gaps.
    setreq(4'b1111);
    for (int n = 0; n < 40; n++) begin
      tick();
      exp8("rr_order", 4'(4'b0001 << ((n / 8) % 4)), 2'((n / 8) % 4), 1'b1);
    end

    // Single requester from idle, held 20 cycles, then released.
    setreq(4'b0000);
    tick();
    exp8("idle_keep_sel", 4'b0000, 2'b00, 1'b0);
    setreq(4'b0100);
    for (int n = 0; n < 20; n++) begin
      tick();
      exp8("single_hold", 4'b0100, 2'b10, 1'b1);
    end
    setreq(4'b0000);
    tick();
    exp8("single_drop", 4'b0000, 2'b10, 1'b0);

    // Reset mid-grant, then first grant searches from 0.
    setreq(4'b0100);
    tick();
    exp8("pre_reset_grant", 4'b0100, 2'b10, 1'b1);
    mid_reset("async_reset");
    setreq(4'b1111);
    tick();
    exp8("post_reset_grant", 4'b0001, 2'b00, 1'b1);

    // Zero-bubble handover 0 -> 1.
    mid_reset("async_reset2");
    setreq(4'b0011);
    tick();
    exp8("handover_own0", 4'b0001, 2'b00, 1'b1);
    tick();
    exp8("handover_hold", 4'b0001, 2'b00, 1'b1);
    setreq(4'b0010);
    tick();
    exp8("handover_new", 4'b0010, 2'b01, 1'b1);

    // Wrap: owner 3 releases while 0 and 1 wait; 0 is next.
    setreq(4'b1000);
    tick();
    exp8("wrap_own3", 4'b1000, 2'b11, 1'b1);
    setreq(4'b1011);
    tick();
    exp8("wrap_hold3", 4'b1000, 2'b11, 1'b1);
    setreq(4'b0011);
    tick();
    exp8("wrap_to0", 4'b0001, 2'b00, 1'b1);

    // Fairness: 0 drops and re-raises while 1 waits; 1 wins and keeps it.
    setreq(4'b0010);
    tick();
    exp8("fair_to1", 4'b0010, 2'b01, 1'b1);
    setreq(4'b0011);
    tick();
    exp8("fair_keep1", 4'b0010, 2'b01, 1'b1);

    // HOLD_MAX=1 alternates every cycle.
    mid_reset("async_reset3");
    setreq(4'b0101);
    for (int n = 0; n < 10; n++) begin
      tick();
      exp1("h1_alternate", (n % 2 == 0) ? 4'b0001 : 4'b0100, (n % 2 == 0) ? 2'b00 : 2'b10, 1'b1);
      check("h1_onehot", 32'($countones(if1.gnt)), 32'd1);
    end

    // Randomized traffic with occasional asynchronous resets; model compares every cycle.
    ra = 4'b0000;
    rb = 4'b0000;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        mid_reset("rand_reset");
      end
      ra = ra ^ 4'($urandom & $urandom & $urandom);
      rb = rb ^ 4'($urandom & $urandom);
      if ($urandom_range(0, 63) == 0) ra = 4'b1111;
      if ($urandom_range(0, 63) == 0) rb = 4'b0000;
      if8.req = ra;
      if1.req = rb;
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
